// File: rtl/line_window_ctrl_pkg.sv
// Shared image-filter definitions: sequencer state encoding, default frame size, window size.
package line_window_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } lwc_state_e;

  localparam int unsigned IMG_WIDTH_DEF  = 640;
  localparam int unsigned IMG_HEIGHT_DEF = 480;
  localparam int unsigned WIN_SIZE       = 3;

endpackage

// File: rtl/raster_pos_counter.sv
// Raster column/row position counter with synchronous clear and end-of-line/end-of-frame flags.
module raster_pos_counter #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned ROW_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_col,
  output logic             last_pixel
);

  assign last_col   = (col == COL_W'(IMG_WIDTH - 1));
  assign last_pixel = last_col && (row == ROW_W'(IMG_HEIGHT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        // Row holds on the final pixel; the next frame start clears it.
        if (!last_pixel) row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/line_window_ctrl.sv
// Line-buffer sequencer for a 3x3 filter window: pixel handshake, window flag and coordinates.
// Optional dropped-pixel counter enabled by defining LWC_DROP_CNT_EN.
module line_window_ctrl
  import line_window_ctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned ROW_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             buf_we_o,
  output logic             win_valid_o,
  input  logic             win_ready_i,
  output logic [COL_W-1:0] win_col_o,
  output logic [ROW_W-1:0] win_row_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [15:0]      drop_cnt_o
);

  lwc_state_e       state;
  logic             accept;
  logic             clr_pos;
  logic             win_hit;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_col;
  logic             last_pixel;

  // Single-slot skid: a new pixel is taken only if the window slot is free or being drained.
  always_comb begin
    in_ready_o = 1'b0;
    unique case (state)
      IDLE:    in_ready_o = 1'b0;
      PRIME:   in_ready_o = 1'b1;
      RUN:     in_ready_o = ~win_valid_o | win_ready_i;
      DRAIN:   in_ready_o = 1'b0;
      default: in_ready_o = 1'b0;
    endcase
  end

  assign buf_we_o = in_valid_i & in_ready_o;
  assign accept   = buf_we_o;
  assign clr_pos  = (state == IDLE) && start_i;
  assign win_hit  = accept && (state == RUN) && (col >= COL_W'(WIN_SIZE - 1));

  raster_pos_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_pos),
    .en        (accept),
    .col       (col),
    .row       (row),
    .last_col  (last_col),
    .last_pixel(last_pixel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      win_valid_o  <= 1'b0;
      win_col_o    <= '0;
      win_row_o    <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state  <= PRIME;
            busy_o <= 1'b1;
          end
        end
        PRIME: begin
          // Two full lines must be buffered before any window can form.
          if (accept && last_col && (row == ROW_W'(1))) state <= RUN;
        end
        RUN: begin
          if (win_hit) begin
            win_valid_o <= 1'b1;
            win_col_o   <= col - COL_W'(1);
            win_row_o   <= row - ROW_W'(1);
          end else if (win_ready_i) begin
            win_valid_o <= 1'b0;
          end
          if (accept && last_pixel) state <= DRAIN;
        end
        DRAIN: begin
          if (!win_valid_o || win_ready_i) begin
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b1;
            busy_o       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LWC_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (clr_pos) begin
      drop_q <= '0;
    end else if (in_valid_i && !in_ready_o && ((state == IDLE) || (state == DRAIN)) &&
                 (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_line_window_ctrl.sv
// Self-checking bench for line_window_ctrl on an 8x6 frame: table vectors plus frame sequences.
module tb_line_window_ctrl;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       win_ready_i = 1'b0;
  logic       in_ready_o, buf_we_o, win_valid_o, busy_o, frame_done_o;
  logic [2:0] win_col_o;
  logic [2:0] win_row_o;
  logic [15:0] drop_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  line_window_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COL_W     (3),
    .ROW_W     (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .buf_we_o    (buf_we_o),
    .win_valid_o (win_valid_o),
    .win_ready_i (win_ready_i),
    .win_col_o   (win_col_o),
    .win_row_o   (win_row_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic start;
    logic valid;
    logic wready;
    logic e_rdy;
    logic e_we;
    logic e_busy;
    logic e_wv;
  } vec_t;

  vec_t tbl[7];

`ifdef LWC_DROP_CNT_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".in_ready"}, in_ready_o, 0);
    chk({tag, ".buf_we"}, buf_we_o, 0);
    chk({tag, ".win_valid"}, win_valid_o, 0);
    chk({tag, ".win_col"}, win_col_o, 0);
    chk({tag, ".win_row"}, win_row_o, 0);
    chk({tag, ".busy"}, busy_o, 0);
    chk({tag, ".frame_done"}, frame_done_o, 0);
    chk({tag, ".drop_cnt"}, drop_cnt_o, 0);
  endtask

  task automatic run_frame(input int gap_pct, input int stall_at, input int stall_len,
                           input bit start_mid, input int abort_at);
    int n_acc, we_cnt, win_cnt, done_cnt, stall_obs, stall_left, exp_wr, exp_wc, exp_drop;
    int first_r, first_c, last_r, last_c;
    bit exp_wv, exp_done, ended, stall_done, exp_rdy, acc, cons;
    n_acc = 0; we_cnt = 0; win_cnt = 0; done_cnt = 0; stall_obs = 0; stall_left = 0;
    exp_wr = 0; exp_wc = 0; exp_drop = 0;
    first_r = -1; first_c = -1; last_r = -1; last_c = -1;
    exp_wv = 0; exp_done = 0; ended = 0; stall_done = 0;
    @(negedge clk);
    start_i = 1'b1; in_valid_i = 1'b0; win_ready_i = 1'b0;
    for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
      @(negedge clk);
      start_i    = start_mid && (n_acc == 20);
      in_valid_i = ($urandom_range(99) >= gap_pct);
      if (!stall_done && stall_len > 0 && n_acc == stall_at) begin
        stall_left = stall_len;
        stall_done = 1;
      end
      win_ready_i = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (n_acc == abort_at) return;
      exp_rdy = (n_acc < W * H) && (n_acc < 2 * W || !exp_wv || win_ready_i);
      chk("in_ready", in_ready_o, exp_rdy);
      chk("buf_we", buf_we_o, in_valid_i && exp_rdy);
      chk("win_valid", win_valid_o, exp_wv);
      if (exp_wv) begin
        chk("win_row", win_row_o, exp_wr);
        chk("win_col", win_col_o, exp_wc);
      end
      chk("busy", busy_o, !exp_done);
      chk("frame_done", frame_done_o, exp_done);
      chk("drop_cnt", drop_cnt_o, exp_drop);
      if (buf_we_o) we_cnt++;
      if (win_valid_o && first_r < 0) begin
        first_r = win_row_o;
        first_c = win_col_o;
      end
      if (win_valid_o && win_ready_i) begin
        win_cnt++;
        last_r = win_row_o;
        last_c = win_col_o;
      end
      if (frame_done_o) done_cnt++;
      if (!in_ready_o && n_acc < W * H) stall_obs++;
      if (exp_done) ended = 1;
      // Reference model update for the coming clock edge.
      acc  = in_valid_i && exp_rdy;
      cons = exp_wv && win_ready_i;
      if (DropEn && in_valid_i && n_acc == W * H) exp_drop++;
      exp_done = (n_acc == W * H) && cons;
      if (acc && (n_acc / W) >= 2 && (n_acc % W) >= 2) begin
        exp_wv = 1;
        exp_wr = n_acc / W - 1;
        exp_wc = n_acc % W - 1;
      end else if (cons) begin
        exp_wv = 0;
      end
      if (acc) n_acc++;
    end
    if (!ended) chk("frame_timeout", 0, 1);
    chk("we_count", we_cnt, W * H);
    chk("win_count", win_cnt, (W - 2) * (H - 2));
    chk("done_pulses", done_cnt, 1);
    chk("stall_cycles", stall_obs, stall_len);
    chk("first_row", first_r, 1);
    chk("first_col", first_c, 1);
    chk("last_row", last_r, H - 2);
    chk("last_col", last_c, W - 2);
    @(negedge clk);
    start_i = 1'b0; in_valid_i = 1'b1; win_ready_i = 1'b1;
    #1;
    chk("post.in_ready", in_ready_o, 0);
    chk("post.buf_we", buf_we_o, 0);
    chk("post.frame_done", frame_done_o, 0);
    chk("post.busy", busy_o, 0);
    chk("post.win_valid", win_valid_o, 0);
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            start valid wready  rdy we busy wv
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start_i     = tbl[i].start;
      in_valid_i  = tbl[i].valid;
      win_ready_i = tbl[i].wready;
      #1;
      chk($sformatf("tbl%0d.in_ready", i), in_ready_o, tbl[i].e_rdy);
      chk($sformatf("tbl%0d.buf_we", i), buf_we_o, tbl[i].e_we);
      chk($sformatf("tbl%0d.busy", i), busy_o, tbl[i].e_busy);
      chk($sformatf("tbl%0d.win_valid", i), win_valid_o, tbl[i].e_wv);
    end
    rst = 1'b0;
    #1;
    check_all_zero("prime_reset");
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; win_ready_i = 1'b0;

    // Valid pixels offered in IDLE are refused and (optionally) counted.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_i = 1'b1;
      #1;
      chk("idle.buf_we", buf_we_o, 0);
      chk("idle.drop_cnt", drop_cnt_o, DropEn ? i : 0);
    end
    @(negedge clk);
    in_valid_i = 1'b0; start_i = 1'b1;
    #1;
    chk("drop_before_start", drop_cnt_o, DropEn ? 10 : 0);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("drop_after_start", drop_cnt_o, 0);
    chk("busy_after_start", busy_o, 1);
    rst = 1'b0;
    #1;
    check_all_zero("drop_reset");
    @(negedge clk);
    rst = 1'b1;

    run_frame(0, -1, 0, 1'b0, -1);
    run_frame(0, 20, 5, 1'b0, -1);
    run_frame(50, -1, 0, 1'b0, -1);
    run_frame(0, -1, 0, 1'b1, -1);

    run_frame(0, -1, 0, 1'b0, 30);
    rst = 1'b0;
    #1;
    check_all_zero("abort_reset");
    @(negedge clk);
    rst = 1'b1; in_valid_i = 1'b0; start_i = 1'b0;
    run_frame(0, -1, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_window_ctrl.md
Name: line_window_ctrl

Overview:
- Sequencer for the two-line FIFO line buffer feeding the 3x3 filter window.
- Accepts a raster pixel stream with a valid/ready handshake and drives the line-buffer write enable.
- Counts column and row positions.
- Flags when a full 3x3 neighbourhood is present, with the window-centre coordinates, under downstream backpressure, and pulses once per frame.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3)
- IMG_HEIGHT, 480, lines per frame (>=3)
- COL_W, 10, column counter width, ceil(log2(IMG_WIDTH))
- ROW_W, 9, row counter width, ceil(log2(IMG_HEIGHT))

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- start_i  in  1  frame start pulse; honoured only in IDLE
- in_valid_i  in  1  upstream pixel valid
- in_ready_o  out  1  controller can accept a pixel
- buf_we_o  out  1  line-buffer write enable = in_valid_i & in_ready_o (combinational)
- win_valid_o  out  1  3x3 window at buffer outputs/window regs is complete
- win_ready_i  in  1  downstream consumed window
- win_col_o  out  COL_W  window-centre column
- win_row_o  out  ROW_W  window-centre row
- busy_o  out  1  high in PRIME/RUN/DRAIN
- frame_done_o  out  1  one-cycle pulse at frame end
- drop_cnt_o  out  16  dropped-pixel count (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=IDLE; col/row counters=0; all outputs 0.
- Accept event: in_valid_i & in_ready_o. Every accept asserts buf_we_o in the same cycle and advances the position.
- Column wraps IMG_WIDTH-1 -> 0 and increments row. No other wrap occurs.
- States:
  - IDLE: in_ready_o=0. start_i=1 -> PRIME, counters cleared.
  - PRIME: in_ready_o=1; win_valid_o stays 0. Accepting pixel (row 1, col IMG_WIDTH-1) -> RUN.
  - RUN: in_ready_o = ~win_valid_o | win_ready_i (single-slot skid; at most one window outstanding). Accepting pixel (r, c) with c>=2:
    - win_valid_o=1 on the next cycle;
    - win_col_o=c-1 and win_row_o=r-1, registered;
    - accepts with c<2 produce no window.
  - RUN, last pixel: accepting (IMG_HEIGHT-1, IMG_WIDTH-1) -> DRAIN; in_ready_o=0 from the next cycle.
  - DRAIN: hold window until win_ready_i. Then win_valid_o=0, frame_done_o=1 for one cycle -> IDLE.
- Window handshake:
  - win_valid_o falls only on win_ready_i with no new window that cycle.
  - Simultaneous consume and new accept -> win_valid_o stays 1 with the updated coordinates.
  - Coordinates are stable while win_valid_o=1 and win_ready_i=0.
- Latency: accept to win_valid_o is 1 cycle.
- Throughput: 1 window/cycle when win_ready_i is held high.
- Windows per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Boundary conditions:
  - start_i outside IDLE: ignored.
  - in_valid_i in IDLE/DRAIN: not accepted, no write.
  - Reset mid-frame: immediate return to IDLE. The line buffer is cleared by its own reset; no partial-frame state survives.
  - in_valid_i low mid-line: counters hold and no write occurs; windows are unaffected.

Optional Feature:
- Macro: LWC_DROP_CNT_EN.
- Defined:
  - drop_cnt_o counts cycles with in_valid_i=1 and in_ready_o=0 while state is IDLE or DRAIN.
  - 16-bit, saturating at 0xFFFF.
  - Cleared by reset and by a start_i honoured in IDLE.
- Undefined: drop_cnt_o tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package (image-filter common):
  - state encoding constants IDLE=2'd0, PRIME=2'd1, RUN=2'd2, DRAIN=2'd3;
  - default IMG_WIDTH/IMG_HEIGHT;
  - WIN_SIZE=3.
- One natural sub-module, raster_pos_counter: col/row counters with enable, clear, and last-column/last-pixel flags. The FSM and window register stay in line_window_ctrl.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=6; start, continuous valid, win_ready_i=1 -> first win_valid_o one cycle after accepting pixel 18 (row 2, col 2) with centre (1,1); 24 windows total; last centre (4,6); frame_done_o single pulse after the last window.
- Same frame with win_ready_i low for 5 cycles mid-row -> in_ready_o low for 5 cycles; coordinates held; no window lost or duplicated; total still 24.
- Random in_valid_i gaps (50%) -> buf_we_o count = 48; window centres match a raster reference model.
- rst low at pixel 30 -> all outputs 0 asynchronously. Fresh start then yields 24 windows starting at centre (1,1).
- start_i pulsed during RUN -> no effect; frame completes normally.
- LWC_DROP_CNT_EN defined: 10 valid cycles in IDLE then start -> drop_cnt_o=10 before start, 0 after. Undefined: drop_cnt_o=0 throughout.
